// File: rtl/reg_file_pkg.sv
// Shared sizing and types for the banked register file.
package reg_file_pkg;

  localparam int unsigned NUM_REGS     = 8;
  localparam int unsigned DATA_WIDTH   = 8;
  localparam int unsigned NUM_REGS_LOG = $clog2(NUM_REGS) - 1;
  localparam int unsigned BANK_REGS    = NUM_REGS / 2;

  typedef logic [DATA_WIDTH-1:0]   reg_data_t;
  typedef logic [NUM_REGS_LOG-1:0] bank_addr_t;
  typedef logic [NUM_REGS_LOG:0]   phys_addr_t;

endpackage

// File: rtl/reg_file_bank.sv
// One bank of the register file: a synchronous write port and two combinational read ports.
module reg_file_bank
  import reg_file_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wen_i,
  input  logic [NUM_REGS_LOG-1:0] rs_addr_i,
  input  logic [NUM_REGS_LOG-1:0] rt_addr_i,
  input  logic [DATA_WIDTH-1:0]   write_data_i,
  output logic [DATA_WIDTH-1:0]   rs_val_o,
  output logic [DATA_WIDTH-1:0]   rt_val_o
);

  reg_data_t regs_q [BANK_REGS];
  reg_data_t regs_d [BANK_REGS];

  always_comb begin
    regs_d = regs_q;
    if (wen_i) begin
      regs_d[bank_addr_t'(rs_addr_i)] = reg_data_t'(write_data_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads come straight from the array: no bypass of an in-flight write.
  assign rs_val_o = regs_q[bank_addr_t'(rs_addr_i)];
  assign rt_val_o = regs_q[bank_addr_t'(rt_addr_i)];

endmodule

// File: rtl/reg_file.sv
// Banked register file: level picks the bank, short addresses index within it.
module reg_file
  import reg_file_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    level,
  input  logic                    wen_i,
  input  logic [NUM_REGS_LOG-1:0] rs_addr_i,
  input  logic [NUM_REGS_LOG-1:0] rt_addr_i,
  input  logic [DATA_WIDTH-1:0]   write_data_i,
  output logic [DATA_WIDTH-1:0]   rs_val_o,
  output logic [DATA_WIDTH-1:0]   rt_val_o
);

  reg_data_t rs_lo_c, rt_lo_c, rs_hi_c, rt_hi_c;
  logic      wen_lo_c, wen_hi_c;

  // Only the selected bank sees the write enable, so the other bank is never touched.
  assign wen_lo_c = wen_i & ~level;
  assign wen_hi_c = wen_i &  level;

  reg_file_bank u_bank_lo (
    .clk          (clk),
    .rst_n        (rst_n),
    .wen_i        (wen_lo_c),
    .rs_addr_i    (rs_addr_i),
    .rt_addr_i    (rt_addr_i),
    .write_data_i (write_data_i),
    .rs_val_o     (rs_lo_c),
    .rt_val_o     (rt_lo_c)
  );

  reg_file_bank u_bank_hi (
    .clk          (clk),
    .rst_n        (rst_n),
    .wen_i        (wen_hi_c),
    .rs_addr_i    (rs_addr_i),
    .rt_addr_i    (rt_addr_i),
    .write_data_i (write_data_i),
    .rs_val_o     (rs_hi_c),
    .rt_val_o     (rt_hi_c)
  );

  assign rs_val_o = level ? rs_hi_c : rs_lo_c;
  assign rt_val_o = level ? rt_hi_c : rt_lo_c;

  // A write with an unknown target register is a stimulus error.
  a_wr_addr_known: assert property (@(posedge clk) disable iff (!rst_n)
    wen_i |-> !$isunknown({level, rs_addr_i}));

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected reads, a negedge monitor checks them.
module tb_reg_file;

  logic       clk;
  logic       rst_n;
  logic       level;
  logic       wen_i;
  logic [1:0] rs_addr_i;
  logic [1:0] rt_addr_i;
  logic [7:0] write_data_i;
  logic [7:0] rs_val_o;
  logic [7:0] rt_val_o;

  typedef struct {
    logic [7:0] rs;
    logic [7:0] rt;
    string      tag;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] model [8];
  int         total = 0;
  int         bad   = 0;

  reg_file dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .level        (level),
    .wen_i        (wen_i),
    .rs_addr_i    (rs_addr_i),
    .rt_addr_i    (rt_addr_i),
    .write_data_i (write_data_i),
    .rs_val_o     (rs_val_o),
    .rt_val_o     (rt_val_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  function automatic int idx(input logic l, input logic [1:0] a);
    return int'(l) * 4 + int'(a);
  endfunction

  task automatic expect_now(input string tag);
    exp_t e;
    e.rs  = model[idx(level, rs_addr_i)];
    e.rt  = model[idx(level, rt_addr_i)];
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Entered at posedge+1; drives one cycle of inputs and advances the model at the edge.
  task automatic cycle(input logic l, input logic w, input logic [1:0] rs,
                       input logic [1:0] rt, input logic [7:0] d, input string tag);
    level = l; wen_i = w; rs_addr_i = rs; rt_addr_i = rt; write_data_i = d;
    if (tag != "") expect_now(tag);
    @(posedge clk);
    if (w && rst_n) model[idx(l, rs)] = d;
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      if (rs_val_o !== e.rs) begin
        bad++;
        $display("FAIL %s rs_val_o: got %02h required %02h (level=%0b rs=%0d)",
                 e.tag, rs_val_o, e.rs, level, rs_addr_i);
      end
      total++;
      if (rt_val_o !== e.rt) begin
        bad++;
        $display("FAIL %s rt_val_o: got %02h required %02h (level=%0b rt=%0d)",
                 e.tag, rt_val_o, e.rt, level, rt_addr_i);
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    rst_n = 1'b0; level = 1'b0; wen_i = 1'b0;
    rs_addr_i = 2'd0; rt_addr_i = 2'd0; write_data_i = 8'h00;
    @(posedge clk); #1;

    // Writes attempted while in reset must be ignored.
    for (int i = 0; i < 8; i++)
      cycle(1'(i / 4), 1'b1, 2'(i % 4), 2'(3 - i % 4), 8'h55, "reset_hold");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      cycle(1'(i / 4), 1'b1, 2'(i % 4), 2'(i % 4), 8'h00, "init_sweep");
    for (int i = 0; i < 8; i++)
      cycle(1'(i / 4), 1'b0, 2'(i % 4), 2'((i + 1) % 4), 8'h00, "init_read");

    cycle(1'b1, 1'b1, 2'd1, 2'd0, 8'hFF, "upper_write");
    cycle(1'b1, 1'b0, 2'd1, 2'd0, 8'h00, "upper_readback");
    cycle(1'b0, 1'b0, 2'd1, 2'd1, 8'hF0, "bank_isolation");
    cycle(1'b1, 1'b0, 2'd1, 2'd1, 8'hF0, "back_to_upper");

    cycle(1'b0, 1'b1, 2'd2, 2'd2, 8'hA5, "rdw_before_edge");
    cycle(1'b0, 1'b0, 2'd2, 2'd2, 8'h00, "rdw_after_edge");

    for (int i = 0; i < 8; i++)
      cycle(1'(i / 4), 1'b1, 2'(i % 4), 2'(i % 4), 8'(8'h10 + i), "");
    for (int l = 0; l < 2; l++)
      for (int s = 0; s < 4; s++)
        for (int t = 0; t < 4; t++)
          cycle(1'(l), 1'b0, 2'(s), 2'(t), 8'hEE, "dual_port_sweep");

    for (int n = 0; n < 300; n++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 8'($urandom), "random");

    // Mid-cycle reset after registers hold nonzero data: outputs clear before any edge.
    for (int i = 0; i < 8; i++) cycle(1'(i / 4), 1'b1, 2'(i % 4), 2'(i % 4), 8'(8'hC0 + i), "");
    level = 1'b1; wen_i = 1'b0; rs_addr_i = 2'd1; rt_addr_i = 2'd2;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    expect_now("async_reset");
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++)
      cycle(1'(i / 4), 1'b0, 2'(i % 4), 2'(3 - i % 4), 8'h00, "reset_clear");
    rst_n = 1'b1;

    for (int n = 0; n < 100; n++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 8'($urandom), "random_post_reset");

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
